// File: rtl/rf_wb_writer.sv
// rf_wb_writer: write-back unit owning the single register-file write port.
//
// Merges EXU results (never back-pressured) and LSU load data (queued in a small FIFO) into
// one registered wb2rf_* write request per cycle; the register file commits it on the
// following negedge. EXU always wins the port; the LSU queue drains when the EXU is idle.
//
// Optional feature macro: RF_WB_SCOREBOARD_EN. When defined, a pending-load vector marks
// destination registers of issued loads and drives wb2id_rs*_busy_o. When undefined, the
// load-issue inputs are ignored and both busy outputs are tied to 0.
//
// XLEN, RF_AWIDTH and RF_SIZE normally come from pcore_interface_defs.svh; fallbacks below
// keep this file self-contained when that header is not on the include path.
//
// Ports:
//   rst_n, clk              async active-low reset, clock
//   exe2wb_*                EXU result (valid, rd, data)
//   lsu2wb_valid_i/ready_o  LSU load data handshake; lsu2wb_rd_addr_i/rd_data_i payload
//   lsu2wb_ld_issue_i       load issued, lsu2wb_ld_rd_addr_i is its destination
//   id2wb_rs1/rs2_addr_i    IDU source register queries
//   wb2id_rs1/rs2_busy_o    source register still awaits load data
//   wb2rf_rd_*              registered register-file write request

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RF_AWIDTH
`define RF_AWIDTH 5
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif

module rf_wb_writer #(
  parameter int unsigned LSU_FIFO_DEPTH = 2
) (
  input  logic                  rst_n,
  input  logic                  clk,
  input  logic                  exe2wb_valid_i,
  input  logic [`RF_AWIDTH-1:0] exe2wb_rd_addr_i,
  input  logic [`XLEN-1:0]      exe2wb_rd_data_i,
  input  logic                  lsu2wb_valid_i,
  output logic                  lsu2wb_ready_o,
  input  logic [`RF_AWIDTH-1:0] lsu2wb_rd_addr_i,
  input  logic [`XLEN-1:0]      lsu2wb_rd_data_i,
  input  logic                  lsu2wb_ld_issue_i,
  input  logic [`RF_AWIDTH-1:0] lsu2wb_ld_rd_addr_i,
  input  logic [`RF_AWIDTH-1:0] id2wb_rs1_addr_i,
  input  logic [`RF_AWIDTH-1:0] id2wb_rs2_addr_i,
  output logic                  wb2id_rs1_busy_o,
  output logic                  wb2id_rs2_busy_o,
  output logic                  wb2rf_rd_wr_req_o,
  output logic [`RF_AWIDTH-1:0] wb2rf_rd_addr_o,
  output logic [`XLEN-1:0]      wb2rf_rd_data_o
);

  localparam int unsigned PtrW = $clog2(LSU_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // LSU result queue
  logic [`RF_AWIDTH-1:0] fifo_addr_q [LSU_FIFO_DEPTH];
  logic [`XLEN-1:0]      fifo_data_q [LSU_FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  fifo_full, fifo_empty;
  logic                  push, pop, exe_sel;
  logic [`RF_AWIDTH-1:0] head_addr;
  logic [`XLEN-1:0]      head_data;

  // Output register
  logic                  wr_req_q, wr_req_d;
  logic [`RF_AWIDTH-1:0] addr_q, addr_d;
  logic [`XLEN-1:0]      data_q, data_d;

  assign fifo_full  = (cnt_q == CntW'(LSU_FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  // Ready follows the registered count only; a same-cycle pop does not make room early.
  assign lsu2wb_ready_o = !fifo_full;
  assign push      = lsu2wb_valid_i && !fifo_full;
  assign exe_sel   = exe2wb_valid_i && (exe2wb_rd_addr_i != '0);
  assign pop       = !exe_sel && !fifo_empty;
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= lsu2wb_rd_addr_i;
      fifo_data_q[wr_ptr_q] <= lsu2wb_rd_data_i;
    end
  end

  always_comb begin
    wr_req_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (exe_sel) begin
      wr_req_d = 1'b1;
      addr_d   = exe2wb_rd_addr_i;
      data_d   = exe2wb_rd_data_i;
    end else if (pop && (head_addr != '0)) begin
      // A popped rd=0 load is dropped silently; addr/data hold.
      wr_req_d = 1'b1;
      addr_d   = head_addr;
      data_d   = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wr_req_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      wr_req_q <= wr_req_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign wb2rf_rd_wr_req_o = wr_req_q;
  assign wb2rf_rd_addr_o   = addr_q;
  assign wb2rf_rd_data_o   = data_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [`RF_SIZE-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (pop && (head_addr != '0)) begin
      pend_d[head_addr] = 1'b0;
    end
    // Set after clear so a same-cycle issue to the same rd keeps it pending.
    if (lsu2wb_ld_issue_i && (lsu2wb_ld_rd_addr_i != '0)) begin
      pend_d[lsu2wb_ld_rd_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign wb2id_rs1_busy_o = pend_q[id2wb_rs1_addr_i];
  assign wb2id_rs2_busy_o = pend_q[id2wb_rs2_addr_i];
`else
  logic unused_sb;
  assign unused_sb = ^{lsu2wb_ld_issue_i, lsu2wb_ld_rd_addr_i,
                       id2wb_rs1_addr_i, id2wb_rs2_addr_i};
  assign wb2id_rs1_busy_o = 1'b0;
  assign wb2id_rs2_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_writer.sv
// Self-checking bench for rf_wb_writer (LSU_FIFO_DEPTH = 2). Inputs change just after the
// negedge; outputs are sampled at the negedge. A scoreboard holds expected EXU and LSU
// writes; a monitor pops and compares them as wb2rf writes appear.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef RF_AWIDTH
`define RF_AWIDTH 5
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif

module tb_rf_wb_writer;

  typedef struct packed {
    logic [`RF_AWIDTH-1:0] a;
    logic [`XLEN-1:0]      d;
  } item_t;

  logic                  rst_n, clk;
  logic                  exe_v;
  logic [`RF_AWIDTH-1:0] exe_a;
  logic [`XLEN-1:0]      exe_d;
  logic                  lsu_v, lsu_rdy;
  logic [`RF_AWIDTH-1:0] lsu_a;
  logic [`XLEN-1:0]      lsu_d;
  logic                  ld_issue;
  logic [`RF_AWIDTH-1:0] ld_a, rs1, rs2;
  logic                  busy1, busy2, wr_req;
  logic [`RF_AWIDTH-1:0] wr_a;
  logic [`XLEN-1:0]      wr_d;

  int    vectors = 0;
  int    miscompares = 0;
  item_t exp_exe[$];
  item_t exp_lsu[$];

  rf_wb_writer #(.LSU_FIFO_DEPTH(2)) dut (
    .rst_n               (rst_n),
    .clk                 (clk),
    .exe2wb_valid_i      (exe_v),
    .exe2wb_rd_addr_i    (exe_a),
    .exe2wb_rd_data_i    (exe_d),
    .lsu2wb_valid_i      (lsu_v),
    .lsu2wb_ready_o      (lsu_rdy),
    .lsu2wb_rd_addr_i    (lsu_a),
    .lsu2wb_rd_data_i    (lsu_d),
    .lsu2wb_ld_issue_i   (ld_issue),
    .lsu2wb_ld_rd_addr_i (ld_a),
    .id2wb_rs1_addr_i    (rs1),
    .id2wb_rs2_addr_i    (rs2),
    .wb2id_rs1_busy_o    (busy1),
    .wb2id_rs2_busy_o    (busy2),
    .wb2rf_rd_wr_req_o   (wr_req),
    .wb2rf_rd_addr_o     (wr_a),
    .wb2rf_rd_data_o     (wr_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: an EXU write is always presented the cycle after it is driven.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_exe.size() > 0) begin
        item_t it;
        it = exp_exe.pop_front();
        vectors++;
        if (wr_req !== 1'b1 || wr_a !== it.a || wr_d !== it.d) begin
          miscompares++;
          $display("FAIL exe_write: got req=%b a=%0d d=%h, want req=1 a=%0d d=%h",
                   wr_req, wr_a, wr_d, it.a, it.d);
        end
      end else if (wr_req === 1'b1) begin
        vectors++;
        if (exp_lsu.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got a=%0d d=%h, want no write", wr_a, wr_d);
        end else begin
          item_t it;
          it = exp_lsu.pop_front();
          if (wr_a !== it.a || wr_d !== it.d) begin
            miscompares++;
            $display("FAIL lsu_write: got a=%0d d=%h, want a=%0d d=%h", wr_a, wr_d, it.a, it.d);
          end
        end
      end
    end
  end

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    exe_v    = 1'b0;
    lsu_v    = 1'b0;
    ld_issue = 1'b0;
  endtask

  task automatic drive_exe(input logic [`RF_AWIDTH-1:0] a, input logic [`XLEN-1:0] d);
    exe_v = 1'b1;
    exe_a = a;
    exe_d = d;
    if (a != '0) exp_exe.push_back('{a: a, d: d});
  endtask

  task automatic drive_lsu(input logic [`RF_AWIDTH-1:0] a, input logic [`XLEN-1:0] d,
                           output logic acc);
    lsu_v = 1'b1;
    lsu_a = a;
    lsu_d = d;
    acc   = lsu_rdy;
    if (acc && a != '0) exp_lsu.push_back('{a: a, d: d});
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while ((exp_exe.size() + exp_lsu.size()) > 0 && n < 20) begin
      next_cyc();
      n++;
    end
    vectors++;
    if ((exp_exe.size() + exp_lsu.size()) != 0) begin
      miscompares++;
      $display("FAIL drain: %0d writes still outstanding, want 0",
               exp_exe.size() + exp_lsu.size());
    end
    next_cyc();
    next_cyc();
  endtask

  task automatic test_reset();
    vectors++;
    if (wr_req !== 1'b0 || wr_a !== '0 || wr_d !== '0) begin
      miscompares++;
      $display("FAIL reset_out: got req=%b a=%0d d=%h, want 0/0/0", wr_req, wr_a, wr_d);
    end
    vectors++;
    if (lsu_rdy !== 1'b1 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got ready=%b busy=%b%b, want ready=1 busy=00",
               lsu_rdy, busy1, busy2);
    end
  endtask

  task automatic test_exu();
    next_cyc(); idle();
    drive_exe(5, 32'hDEADBEEF);
    next_cyc(); idle();
    vectors++;
    if (wr_req !== 1'b1 || wr_a !== 5) begin
      miscompares++;
      $display("FAIL exu_latency: got req=%b a=%0d, want req=1 a=5", wr_req, wr_a);
    end
    next_cyc();
    vectors++;
    if (wr_req !== 1'b0) begin
      miscompares++;
      $display("FAIL exu_single: got req=%b, want 0", wr_req);
    end
    drain();
  endtask

  task automatic test_same_cycle();
    logic acc;
    next_cyc(); idle();
    drive_exe(3, 32'h11);
    drive_lsu(4, 32'h22, acc);
    next_cyc(); idle();
    vectors++;
    if (wr_req !== 1'b1 || wr_a !== 3 || wr_d !== 32'h11) begin
      miscompares++;
      $display("FAIL same_exe: got req=%b a=%0d d=%h, want 1/3/11", wr_req, wr_a, wr_d);
    end
    next_cyc();
    vectors++;
    if (wr_req !== 1'b1 || wr_a !== 4 || wr_d !== 32'h22) begin
      miscompares++;
      $display("FAIL same_lsu: got req=%b a=%0d d=%h, want 1/4/22", wr_req, wr_a, wr_d);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   pushed = 0;
    int   guard = 0;
    for (int i = 0; i < 6; i++) begin
      next_cyc(); idle();
      drive_exe(`RF_AWIDTH'(10 + i), 32'h100 + i);
      if (pushed < 3) begin
        vectors++;
        if (lsu_rdy !== (i < 2)) begin
          miscompares++;
          $display("FAIL bp_ready[%0d]: got %b, want %b", i, lsu_rdy, (i < 2));
        end
        drive_lsu(`RF_AWIDTH'(20 + pushed), 32'h200 + pushed, acc);
        if (acc) pushed++;
      end
    end
    while (pushed < 3 && guard < 10) begin
      next_cyc(); idle();
      drive_lsu(`RF_AWIDTH'(20 + pushed), 32'h200 + pushed, acc);
      if (acc) pushed++;
      guard++;
    end
    vectors++;
    if (pushed != 3) begin
      miscompares++;
      $display("FAIL bp_accept: got %0d pushes, want 3", pushed);
    end
    next_cyc();
    drain();
  endtask

  task automatic test_rd0();
    logic acc;
    next_cyc(); idle();
    drive_exe(0, 32'h55);
    next_cyc(); idle();
    vectors++;
    if (wr_req !== 1'b0) begin
      miscompares++;
      $display("FAIL exe_rd0: got req=%b, want 0", wr_req);
    end
    drive_lsu(0, 32'h66, acc);
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL lsu_rd0_accept: got ready=%b, want 1", acc);
    end
    next_cyc(); idle();
    drive_lsu(9, 32'h99, acc);
    next_cyc(); idle();
    vectors++;
    if (wr_req !== 1'b0) begin
      miscompares++;
      $display("FAIL lsu_rd0_drop: got req=%b a=%0d, want req=0", wr_req, wr_a);
    end
    next_cyc();
    vectors++;
    if (wr_req !== 1'b1 || wr_a !== 9) begin
      miscompares++;
      $display("FAIL lsu_after_rd0: got req=%b a=%0d, want 1/9", wr_req, wr_a);
    end
    ld_issue = 1'b1;
    ld_a     = 0;
    rs1      = 0;
    next_cyc(); idle();
    vectors++;
    if (busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rs1_zero_busy: got %b, want 0", busy1);
    end
    drain();
  endtask

  task automatic test_scoreboard();
    logic acc;
    rs1 = 7;
    rs2 = 8;
    next_cyc(); idle();
    ld_issue = 1'b1;
    ld_a     = 7;
    next_cyc(); idle();
`ifdef RF_WB_SCOREBOARD_EN
    vectors++;
    if (busy1 !== 1'b1 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_set: got busy=%b%b, want rs1=1 rs2=0", busy1, busy2);
    end
    drive_lsu(7, 32'h77, acc);
    next_cyc(); idle();
    vectors++;
    if (busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_queued: got busy=%b, want 1", busy1);
    end
    next_cyc();
    vectors++;
    if (wr_req !== 1'b1 || wr_a !== 7 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_clear: got req=%b a=%0d busy=%b, want 1/7/0", wr_req, wr_a, busy1);
    end
    // Load data for rd=7 leaves the queue in the same cycle a new rd=7 load issues.
    ld_issue = 1'b1;
    ld_a     = 7;
    drive_lsu(7, 32'h78, acc);
    next_cyc(); idle();
    ld_issue = 1'b1;
    ld_a     = 7;
    next_cyc(); idle();
    vectors++;
    if (wr_req !== 1'b1 || wr_a !== 7 || busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL sb_set_wins: got req=%b a=%0d busy=%b, want 1/7/1", wr_req, wr_a, busy1);
    end
    drive_lsu(7, 32'h79, acc);
    next_cyc(); idle();
    next_cyc();
    vectors++;
    if (busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_final_clear: got busy=%b, want 0", busy1);
    end
`else
    vectors++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL sb_disabled: got busy=%b%b, want 00", busy1, busy2);
    end
    acc = 1'b0;
`endif
    drain();
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 80; i++) begin
      next_cyc(); idle();
      if ($urandom_range(0, 1) == 1)
        drive_exe(`RF_AWIDTH'($urandom_range(0, 31)), $urandom);
      if (lsu_rdy && $urandom_range(0, 1) == 1)
        drive_lsu(`RF_AWIDTH'($urandom_range(0, 31)), $urandom, acc);
    end
    next_cyc();
    drain();
  endtask

  task automatic test_reset_mid();
    logic acc;
    next_cyc(); idle();
    drive_exe(1, 32'hA1);
    drive_lsu(2, 32'hA2, acc);
    next_cyc(); idle();
    drive_exe(3, 32'hA3);
    drive_lsu(4, 32'hA4, acc);
    next_cyc(); idle();
    drive_exe(5, 32'hA5);
    next_cyc(); idle();
    vectors++;
    if (wr_req !== 1'b1 || lsu_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset: got req=%b ready=%b, want req=1 ready=0", wr_req, lsu_rdy);
    end
    rst_n = 1'b0;
    #1;
    exp_exe.delete();
    exp_lsu.delete();
    vectors++;
    if (wr_req !== 1'b0 || wr_a !== '0 || wr_d !== '0 || lsu_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: got req=%b a=%0d d=%h ready=%b, want 0/0/0 ready=1",
               wr_req, wr_a, wr_d, lsu_rdy);
    end
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cyc();
      vectors++;
      if (wr_req !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset[%0d]: got req=%b a=%0d, want req=0", i, wr_req, wr_a);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    exe_a = '0; exe_d = '0;
    lsu_a = '0; lsu_d = '0;
    ld_a  = '0; rs1 = '0; rs2 = '0;
    next_cyc();
    test_reset();
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    test_reset();
    test_exu();
    test_same_cycle();
    test_back_to_back();
    test_rd0();
    test_scoreboard();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
